// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared opcodes, FSM state encoding and counter pin idle
//                levels for the dual 4-bit counter command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Command opcodes carried on CMD_OP
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LD   = 3'd2,
    ST_RUN  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Inactive levels of the active-low counter control pins
  localparam logic SR_IDLE = 1'b1;
  localparam logic PE_IDLE = 1'b1;

  // RUN event count: a request of zero means a full sixteen events
  function automatic logic [4:0] event_load(input logic [3:0] count);
    return (count == 4'd0) ? 5'd16 : {1'b0, count};
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_ctrl_seq_tc_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tc_event_counter
//  Description : Terminal-count event down-counter and RUN watchdog. Flags
//                the edge carrying the final requested event and the edge on
//                which the watchdog expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_event_counter
  import counter_pkg::*;
#(
  parameter int            TW      = 8,
  parameter logic [TW-1:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       run,
  input  logic [1:0] sel_in,
  input  logic [3:0] count_in,
  input  logic       tc1,
  input  logic       tc2,
  output logic       last_event,
  output logic       timeout
);

  localparam logic [TW-1:0] WD_LAST = TIMEOUT - 1'b1;

  logic [1:0]    sel;
  logic [4:0]    remaining;
  logic [TW-1:0] wd;
  logic          tc_event;

  // Simultaneous TC1/TC2 on one edge collapse into a single event
  assign tc_event   = (sel[0] & tc1) | (sel[1] & tc2);
  assign last_event = run && tc_event && (remaining == 5'd1);
  assign timeout    = run && (wd == WD_LAST);

  // Latch selection and event budget at RUN accept, then count down and age the watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 2'b00;
      remaining <= 5'd0;
      wd        <= '0;
    end else if (load) begin
      sel       <= sel_in;
      remaining <= event_load(count_in);
      wd        <= '0;
    end else if (run) begin
      if (tc_event && (remaining != 5'd0)) begin
        remaining <= remaining - 5'd1;
      end
      wd <= wd + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl_seq
//  Description : Command sequencer for a dual 4-bit counter. Executes CLEAR,
//                LOAD and RUN commands taken over a valid/ready handshake,
//                pulses DONE on completion and raises a sticky ERR when a
//                RUN exceeds its watchdog budget.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl_seq
  import counter_pkg::*;
#(
  parameter int            TW      = 8,
  parameter logic [TW-1:0] TIMEOUT = 8'd255
) (
  input  logic       CP,
  input  logic       MR,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [1:0] CMD_SEL,
  input  logic [3:0] CMD_DATA,
  input  logic       TC1,
  input  logic       TC2,
  output logic [3:0] P,
  output logic       SR1,
  output logic       SR2,
  output logic       PE,
  output logic       CEP,
  output logic       CET,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  state_t state;
  logic   accept;
  logic   run_load;
  logic   in_run;
  logic   last_event;
  logic   timeout;

  // Ready is the only combinational output; it must drop the moment MR rises
  assign CMD_READY = (state == ST_IDLE) && !MR;
  assign accept    = CMD_VALID && CMD_READY;
  assign run_load  = accept && (CMD_OP == OP_RUN);
  assign in_run    = (state == ST_RUN);

  tc_event_counter #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_tc_event_counter (
    .clk        (CP),
    .rst        (MR),
    .load       (run_load),
    .run        (in_run),
    .sel_in     (CMD_SEL),
    .count_in   (CMD_DATA),
    .tc1        (TC1),
    .tc2        (TC2),
    .last_event (last_event),
    .timeout    (timeout)
  );

  // Command FSM; every pin output is set on the edge entering the state it belongs to
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= ST_IDLE;
      P     <= 4'd0;
      SR1   <= SR_IDLE;
      SR2   <= SR_IDLE;
      PE    <= PE_IDLE;
      CEP   <= 1'b0;
      CET   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to their idle levels unless re-driven below
      DONE <= 1'b0;
      SR1  <= SR_IDLE;
      SR2  <= SR_IDLE;
      PE   <= PE_IDLE;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ERR <= 1'b0;
            case (CMD_OP)
              OP_CLEAR: begin
                state <= ST_CLR;
                SR1   <= ~CMD_SEL[0];
                SR2   <= ~CMD_SEL[1];
                BUSY  <= 1'b1;
              end
              OP_LOAD: begin
                state <= ST_LD;
                P     <= CMD_DATA;
                PE    <= 1'b0;
                BUSY  <= 1'b1;
              end
              OP_RUN: begin
                state <= ST_RUN;
                CEP   <= 1'b1;
                CET   <= 1'b1;
                BUSY  <= 1'b1;
              end
              default: begin
                state <= ST_FIN;
                DONE  <= 1'b1;
              end
            endcase
          end
        end
        ST_CLR, ST_LD: begin
          state <= ST_FIN;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        ST_RUN: begin
          // Reaching the final event wins over a watchdog expiring on the same edge
          if (last_event || timeout) begin
            state <= ST_FIN;
            CEP   <= 1'b0;
            CET   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            ERR   <= !last_event;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
